// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type, iteration count and small op-decode helpers.
// ---------------------------------------------------------------------------
package mdu_pkg;

    // Iterations per operation; one radix-2 step per bit of a 32-bit operand.
    localparam int MDU_ITER = 32;

    // Encoding of the i_op input. Bit 1 picks divide vs multiply, and bit 0
    // picks unsigned vs signed.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// ---------------------------------------------------------------------------
// mdu_step
// One combinational radix-2 iteration, shared by multiply and divide.
//   i_is_div : 0 = shift-add multiply step, 1 = restoring divide step
//   i_acc    : upper word of the working pair (partial product / remainder)
//   i_opnd   : multiplicand (multiply) or divisor (divide) magnitude
//   i_low    : lower word (multiplier bits / dividend bits and quotient)
//   o_acc    : next upper word
//   o_low    : next lower word
// ---------------------------------------------------------------------------
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_opnd,
    input  logic [WIDTH-1:0] i_low,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_low
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Multiply consumes multiplier bits from the LSB of the low word and
    // shifts the product right into it. The add carries one extra bit, and
    // that bit becomes the new MSB after the shift.
    // Divide shifts the pair left, bringing one dividend bit into the
    // remainder. It then subtracts the divisor if that does not go negative,
    // and the quotient bit enters at the LSB of the low word.
    // The shifted remainder can need WIDTH+1 bits. When the subtraction
    // succeeds, the difference is always below the divisor, so WIDTH bits of
    // it are enough.
    always_comb begin
        sum     = {1'b0, i_acc} + {1'b0, i_opnd};
        shifted = {i_acc, i_low[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - i_opnd;
        o_acc   = i_acc;
        o_low   = i_low;
        if (!i_is_div) begin
            if (i_low[0]) begin
                {o_acc, o_low} = {sum, i_low[WIDTH-1:1]};
            end else begin
                {o_acc, o_low} = {1'b0, i_acc, i_low[WIDTH-1:1]};
            end
        end else begin
            if (shifted >= {1'b0, i_opnd}) begin
                o_acc = diff;
                o_low = {i_low[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = shifted[WIDTH-1:0];
                o_low = {i_low[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// ---------------------------------------------------------------------------
// mdu_iterative
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. It owns the
// architectural HI/LO registers.
// Ports:
//   i_clk, i_a_rst_n : clock (rising edge), asynchronous active-low reset
//   i_flush          : blocks start / HI-LO read / MTHI-MTLO this cycle
//   i_start, i_op    : begin an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   i_a, i_b         : rs (dividend), rt (divisor)
//   i_rd_hilo        : EX holds MFHI/MFLO
//   i_hi_we, i_lo_we : MTHI / MTLO, with data on i_wdata
//   o_hi, o_lo       : HI/LO registers
//   o_busy           : operation in progress
//   o_stall          : combinational pipeline hold request
//   o_done           : one-cycle pulse after an operation updates HI/LO
// ---------------------------------------------------------------------------
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_a_rst_n,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_rd_hilo,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    mdu_op_e          op_q;
    mdu_op_e          op_in;
    logic             sign_a_q, sign_b_q, div_zero_q;
    logic [WIDTH-1:0] acc_q, low_q, opnd_q, a_raw_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             accept;
    logic             last_step;
    logic             in_sign_a, in_sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] acc_nxt, low_nxt;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign op_in     = mdu_op_e'(i_op);
    assign accept    = (state_q == IDLE) && i_start && !i_flush;
    assign last_step = (cnt_q == LAST_CNT);

    // The core only iterates on magnitudes. For the unsigned ops the sign
    // flags are forced to zero, so FIX never corrects an unsigned result.
    assign in_sign_a = op_is_signed(op_in) & i_a[WIDTH-1];
    assign in_sign_b = op_is_signed(op_in) & i_b[WIDTH-1];
    assign mag_a     = in_sign_a ? -i_a : i_a;
    assign mag_b     = in_sign_b ? -i_b : i_b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (op_is_div(op_q)),
        .i_acc    (acc_q),
        .i_opnd   (opnd_q),
        .i_low    (low_q),
        .o_acc    (acc_nxt),
        .o_low    (low_nxt)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. i_flush only gates entry from IDLE. An operation
    // that is already running always finishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (last_step) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Iteration datapath. On accept the working pair is loaded as follows.
    //   Multiply: acc=0, low=multiplier, opnd=multiplicand.
    //   Divide:   acc=0, low=dividend,   opnd=divisor.
    // The raw dividend is kept because a divide by zero returns it unchanged
    // in HI. The magnitude would be wrong for negative operands.
    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            cnt_q      <= '0;
            op_q       <= OP_MULT;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            acc_q      <= '0;
            low_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
        end else if (accept) begin
            cnt_q      <= '0;
            op_q       <= op_in;
            sign_a_q   <= in_sign_a;
            sign_b_q   <= in_sign_b;
            div_zero_q <= (i_b == '0);
            acc_q      <= '0;
            low_q      <= op_is_div(op_in) ? mag_a : mag_b;
            opnd_q     <= op_is_div(op_in) ? mag_b : mag_a;
            a_raw_q    <= i_a;
        end else if (state_q == CALC) begin
            acc_q <= acc_nxt;
            low_q <= low_nxt;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sign correction applied in FIX.
    //   Multiply: the whole double-width product is negated when the operand
    //   signs differ.
    //   Divide: the quotient is negated when the signs differ, and the
    //   remainder follows the sign of the dividend.
    // 0x80000000 / -1 needs no special case. Its quotient magnitude is
    // 0x80000000, and negating that gives the same bit pattern back.
    always_comb begin
        fix_hi = acc_q;
        fix_lo = low_q;
        if (!op_is_div(op_q)) begin
            if (sign_a_q ^ sign_b_q) begin
                {fix_hi, fix_lo} = -{acc_q, low_q};
            end
        end else if (div_zero_q) begin
            fix_hi = a_raw_q;
            fix_lo = '1;
        end else begin
            if (sign_a_q ^ sign_b_q) fix_lo = -low_q;
            if (sign_a_q)            fix_hi = -acc_q;
        end
    end

    // HI/LO registers. Two sources can write them.
    //   FIX: writes the result of an operation.
    //   MTHI/MTLO: write only in IDLE. A simultaneous start takes priority
    //   and drops the write. While busy the writer is stalled and presents
    //   the write again later.
    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if ((state_q == IDLE) && !i_start && !i_flush) begin
            if (i_hi_we) hi_q <= i_wdata;
            if (i_lo_we) lo_q <= i_wdata;
        end
    end

    // Completion pulse, in the cycle right after the FIX write.
    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
        end
    end

    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;
    assign o_stall = o_busy && (i_start || i_rd_hilo || i_hi_we || i_lo_we) && !i_flush;

endmodule

// File: tb/tb_mdu_iterative.sv
// ---------------------------------------------------------------------------
// tb_mdu_iterative
// Directed bench for mdu_iterative. Expected HI/LO values come from a
// behavioural arithmetic model. They are queued when an operation is
// started and compared when the unit signals completion.
// ---------------------------------------------------------------------------
module tb_mdu_iterative;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        i_clk = 1'b0;
    logic        i_a_rst_n;
    logic        i_flush;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_rd_hilo;
    logic        i_hi_we;
    logic        i_lo_we;
    logic [31:0] i_wdata;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_stall;
    logic        o_done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] expHi = 32'h0;
    logic [31:0] expLo = 32'h0;

    mdu_iterative #(.WIDTH(32), .CNT_W(6)) dut (
        .i_clk     (i_clk),
        .i_a_rst_n (i_a_rst_n),
        .i_flush   (i_flush),
        .i_start   (i_start),
        .i_op      (i_op),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_rd_hilo (i_rd_hilo),
        .i_hi_we   (i_hi_we),
        .i_lo_we   (i_lo_we),
        .i_wdata   (i_wdata),
        .o_hi      (o_hi),
        .o_lo      (o_lo),
        .o_busy    (o_busy),
        .o_stall   (o_stall),
        .o_done    (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural reference built on the simulator's own arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        hi  = 32'h0;
        lo  = 32'h0;
        case (op)
            OP_MULT: begin
                p  = 64'(sa * sbv);
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'h0, a} * {32'h0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_DIV: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    q  = sa / sbv;
                    r  = sa % sbv;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a start for one edge and queues the modelled result.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input string tag);
        exp_t e;
        model(op, a, b, e.hi, e.lo);
        e.tag = tag;
        sb.push_back(e);
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic popCompare();
        exp_t e;
        checkOutput("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({e.tag, "_hi"}, o_hi, e.hi);
            checkOutput({e.tag, "_lo"}, o_lo, e.lo);
            expHi = e.hi;
            expLo = e.lo;
        end
    endtask

    // One complete operation. It checks the busy length, the single done
    // pulse and the result.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        int busyCycles = 0;
        int cyc = 0;
        applyStimulus(op, a, b, tag);
        while (!o_done && cyc < 100) begin
            if (o_busy) busyCycles++;
            tick();
            cyc++;
        end
        checkOutput({tag, "_done_seen"}, 32'(o_done), 32'd1);
        checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'd33);
        checkOutput({tag, "_busy_clear"}, 32'(o_busy), 32'd0);
        popCompare();
        tick();
        checkOutput({tag, "_done_single"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stallCnt;
        int n;
        i_a_rst_n = 1'b0;
        i_flush   = 1'b0;
        i_start   = 1'b0;
        i_op      = OP_MULT;
        i_a       = 32'h0;
        i_b       = 32'h0;
        i_rd_hilo = 1'b0;
        i_hi_we   = 1'b0;
        i_lo_we   = 1'b0;
        i_wdata   = 32'h0;

        // Reset state
        #23;
        checkOutput("rst_hi",    o_hi, 32'h0);
        checkOutput("rst_lo",    o_lo, 32'h0);
        checkOutput("rst_busy",  32'(o_busy), 32'd0);
        checkOutput("rst_done",  32'(o_done), 32'd0);
        checkOutput("rst_stall", 32'(o_stall), 32'd0);
        i_a_rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        checkOutput("multu_max_hi_const", o_hi, 32'hFFFF_FFFE);
        checkOutput("multu_max_lo_const", o_lo, 32'h0000_0001);
        runOp(OP_MULT,  32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        checkOutput("mult_neg3x7_lo_const", o_lo, 32'hFFFF_FFEB);
        runOp(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        checkOutput("div_neg7by2_lo_const", o_lo, 32'hFFFF_FFFD);
        checkOutput("div_neg7by2_hi_const", o_hi, 32'hFFFF_FFFF);
        runOp(OP_DIVU,  32'd100, 32'd7, "divu_100by7");
        checkOutput("divu_100by7_lo_const", o_lo, 32'd14);
        checkOutput("divu_100by7_hi_const", o_hi, 32'd2);
        runOp(OP_DIVU,  32'h1234, 32'h0, "divu_by0");
        checkOutput("divu_by0_lo_const", o_lo, 32'hFFFF_FFFF);
        runOp(OP_DIV,   32'hFFFF_FF00, 32'h0, "div_neg_by0");
        runOp(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        checkOutput("div_ovf_lo_const", o_lo, 32'h8000_0000);
        runOp(OP_DIV,   32'd7, 32'hFFFF_FFFE, "div_7byneg2");
        runOp(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minsq");

        // A few random operands over all four ops
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            runOp(2'(i), ra, rb, $sformatf("rand%0d", i));
        end

        // Stall while busy, and a repeated start that must be ignored
        applyStimulus(OP_MULT, 32'hFFFF_FFFB, 32'd6, "mult_stall");
        n = 0;
        stallCnt = 0;
        while (o_busy && n < 100) begin
            i_rd_hilo = (n >= 4);
            i_start   = (n >= 10 && n < 12);
            i_op      = OP_DIVU;
            i_a       = 32'd99;
            i_b       = 32'd3;
            #1;
            if (o_stall) stallCnt++;
            if (n == 10) checkOutput("stall_on_restart", 32'(o_stall), 32'd1);
            tick();
            n++;
        end
        i_start = 1'b0;
        #1;
        checkOutput("stall_cycles", 32'(stallCnt), 32'd29);
        checkOutput("stall_released", 32'(o_stall), 32'd0);
        checkOutput("stall_done", 32'(o_done), 32'd1);
        checkOutput("mfhi_new_hi", o_hi, 32'hFFFF_FFFF);
        popCompare();
        i_rd_hilo = 1'b0;
        tick();
        checkOutput("restart_ignored", 32'(o_busy), 32'd0);

        // Flushed start and flushed MTLO have no effect
        i_flush = 1'b1;
        i_start = 1'b1;
        i_op    = OP_MULTU;
        i_a     = 32'd9;
        i_b     = 32'd9;
        i_lo_we = 1'b1;
        i_wdata = 32'h1111_2222;
        tick();
        i_start = 1'b0;
        i_lo_we = 1'b0;
        i_flush = 1'b0;
        checkOutput("flush_busy", 32'(o_busy), 32'd0);
        tick();
        checkOutput("flush_busy_later", 32'(o_busy), 32'd0);
        checkOutput("flush_hi", o_hi, expHi);
        checkOutput("flush_lo", o_lo, expLo);

        // MTLO / MTHI in idle
        i_lo_we = 1'b1;
        i_wdata = 32'hCAFE_F00D;
        tick();
        i_lo_we = 1'b0;
        checkOutput("mtlo_lo", o_lo, 32'hCAFE_F00D);
        checkOutput("mtlo_hi_kept", o_hi, expHi);
        i_hi_we = 1'b1;
        i_wdata = 32'h0BAD_BEEF;
        tick();
        i_hi_we = 1'b0;
        checkOutput("mthi_hi", o_hi, 32'h0BAD_BEEF);
        checkOutput("mthi_lo_kept", o_lo, 32'hCAFE_F00D);

        // Reset in the middle of a divide
        applyStimulus(OP_DIV, 32'h7FFF_0000, 32'd13, "div_aborted");
        repeat (9) tick();
        i_a_rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(o_busy), 32'd0);
        checkOutput("abort_hi", o_hi, 32'h0);
        checkOutput("abort_lo", o_lo, 32'h0);
        checkOutput("abort_done", 32'(o_done), 32'd0);
        sb.delete();
        #3;
        i_a_rst_n = 1'b1;
        tick();
        runOp(OP_MULTU, 32'd3, 32'd5, "multu_3x5");
        checkOutput("multu_3x5_lo_const", o_lo, 32'd15);
        checkOutput("multu_3x5_hi_const", o_hi, 32'd0);

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative multiply/divide unit for the EX stage. It consumes operands latched by the ID/EX pipeline register and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Produces a stall request that the hazard logic routes to the upstream pipe registers' write enables. Dependent instructions are held until HI/LO are valid.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_a_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous qualifier: suppresses i_start, i_rd_hilo and the HI/LO writes in the same cycle.
- i_start  in  1  EX instruction is a mult/div.
- i_op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_a  in  WIDTH  operand rs (dividend).
- i_b  in  WIDTH  operand rt (divisor).
- i_rd_hilo  in  1  EX instruction is MFHI/MFLO.
- i_hi_we  in  1  MTHI write.
- i_lo_we  in  1  MTLO write.
- i_wdata  in  WIDTH  MTHI/MTLO data.
- o_hi  out  WIDTH  HI register.
- o_lo  out  WIDTH  LO register.
- o_busy  out  1  operation in progress.
- o_stall  out  1  pipeline hold request, combinational.
- o_done  out  1  one-cycle pulse after HI/LO are updated by an operation.

Behaviour:
- Reset (async, i_a_rst_n=0):
  - state=IDLE; counter=0.
  - o_hi=0, o_lo=0, o_busy=0, o_done=0.
  - Reset during an operation aborts it; HI/LO are cleared.
- States:
  - IDLE: if i_start & !i_flush, latch the operand magnitudes, the sign flags and i_op; go to CALC with counter=0.
  - CALC: one radix-2 step per cycle (shift-add multiply / restoring divide); counter++. After WIDTH steps, go to FIX.
  - FIX: apply sign correction and write HI/LO; pulse o_done next cycle; go to IDLE.
- Latency:
  - Start sampled at edge E0; CALC steps occupy edges E1..E32; FIX writes HI/LO at E33.
  - o_busy=1 in the 33 cycles following E0 (through E33 inclusive of the FIX cycle).
  - o_done=1 for the single cycle after E33.
  - A new start is accepted in the cycle following E33.
- Multiply result: HI:LO = full 2*WIDTH-bit product.
  - MULT: signed; product negated in FIX if sign(a)^sign(b).
  - MULTU: unsigned.
- Divide result: LO = quotient, HI = remainder.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero (i_b=0), for DIV and DIVU: LO=0xFFFFFFFF, HI=i_a unchanged. No sign correction. Same latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No exception.
- o_stall = o_busy & (i_start | i_rd_hilo | i_hi_we | i_lo_we) & !i_flush.
  - While busy, a new start is ignored (not queued). The stalled instruction re-presents it each cycle.
- MTHI/MTLO in IDLE with no start: write o_hi/o_lo at the next edge.
  - If i_start and i_hi_we assert together in IDLE, the start wins and the write is dropped. This cannot occur from legal decode.
- i_flush does not abort an operation already in CALC/FIX; it only blocks new start/read/write requests that cycle.
- HI/LO hold their old values throughout CALC; they are updated only in FIX or by MTHI/MTLO.

Decomposition:
- Shared package mdu_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - state enum IDLE/CALC/FIX.
  - constant MDU_ITER=32.
- One sub-module, mdu_step:
  - combinational single iteration: shift-add or restore-subtract, selected by op class.
  - inputs: acc, multiplicand/divisor, low word.
  - outputs: next acc and next low word.
- FSM, counter, sign handling and HI/LO registers stay in mdu_iterative.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001; o_done pulses once.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=7 -> LO=14, HI=2. DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234.
- Start MULT, then i_rd_hilo=1 at cycle 5 -> o_stall=1 cycles 5..33, 0 afterwards; MFHI sees the new HI. Second i_start while busy -> ignored, o_stall=1.
- i_start with i_flush=1 -> o_busy stays 0, HI/LO unchanged. MTLO 0xCAFEF00D in IDLE -> o_lo=0xCAFEF00D next cycle.
- Assert i_a_rst_n=0 at cycle 10 of a DIV -> immediately o_busy=0, HI=LO=0. After release, a new MULTU 3*5 yields LO=15, HI=0.
